// File: rtl/lfsr_prng_gen.sv
// Fibonacci LFSR pseudo-random generator with counted / free-running bursts,
// seed load, stop/abort and automatic recovery from the all-zero lock-up state.
module lfsr_prng_gen #(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  TAPS  = 8'h1D,
  parameter logic [WIDTH-1:0]  SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int                CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WIDTH-1:0]  seed_in,
  input  logic              start,
  input  logic [CNT_W-1:0]  steps,
  input  logic              stop,
  output logic [WIDTH-1:0]  data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              done,
  output logic              lockup
);

  generate
    if (SEED == '0) begin : g_bad_seed
      $error("lfsr_prng_gen: SEED must be nonzero");
    end
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_prng_gen: WIDTH must be in 2..32");
    end
  endgenerate

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} fsm_t;

  fsm_t              r_fsm;
  fsm_t              w_fsm_nxt;
  logic [WIDTH-1:0]  r_state;
  logic [WIDTH-1:0]  w_state_nxt;
  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  w_rem_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              r_lock;
  logic              w_lock_nxt;
  logic              w_step;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {^(s & TAPS), s[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // A remaining count of zero while running means free-run: it never ends on its own.
  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      S_IDLE: if (start) w_fsm_nxt = S_RUN;
      S_RUN: begin
        if (stop)                                w_fsm_nxt = S_IDLE;
        else if (!load && r_rem == CNT_W'(1))    w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_step      = (r_fsm == S_RUN) && !load && !stop;
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_lock_nxt  = r_lock;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    if (r_fsm == S_IDLE && start) begin
      w_rem_nxt  = steps;
      w_lock_nxt = 1'b0;
    end
    if (load) begin
      w_state_nxt = seed_in;
      if (seed_in != '0) w_lock_nxt = 1'b0;
    end else if (w_step) begin
      w_valid_nxt = 1'b1;
      // The all-zero state is a fixed point of the XOR feedback; escape to SEED.
      if (r_state == '0) begin
        w_state_nxt = SEED;
        w_lock_nxt  = 1'b1;
      end else begin
        w_state_nxt = lfsr_step(r_state);
      end
      if (r_rem != '0) begin
        w_rem_nxt  = r_rem - CNT_W'(1);
        w_done_nxt = (r_rem == CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
      r_rem   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      r_lock  <= w_lock_nxt;
    end
  end

  assign data_out   = r_state;
  assign data_valid = r_valid;
  assign busy       = (r_fsm == S_RUN);
  assign done       = r_done;
  assign lockup     = r_lock;

endmodule

// File: tb/tb_lfsr_prng_gen.sv
// Directed bench for lfsr_prng_gen at default parameters (8-bit, taps 0x1D, seed 0x01).
module tb_lfsr_prng_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [7:0]  seed_in;
  logic        start;
  logic [15:0] steps;
  logic        stop;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        lockup;

  int errors = 0;
  int checks = 0;

  lfsr_prng_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .seed_in    (seed_in),
    .start      (start),
    .steps      (steps),
    .stop       (stop),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .done       (done),
    .lockup     (lockup)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [7:0]  sd;
    logic        st;
    logic [15:0] n;
    logic        sp;
    logic [7:0]  e_data;
    logic        e_vld;
    logic        e_busy;
    logic        e_done;
    logic        e_lock;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outs();
    return {data_out, data_valid, busy, done, lockup};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int  cnt;
    logic found, rep, done_seen, bad;
    logic seen [256];

    //            ld  sd     st n      sp  data   v  b  d  l
    vecs[0]  = '{0, 8'h00, 0, 16'd0, 0, 8'h01, 0, 0, 0, 0};
    vecs[1]  = '{0, 8'h00, 1, 16'd3, 0, 8'h01, 0, 1, 0, 0};
    vecs[2]  = '{0, 8'h00, 0, 16'd0, 0, 8'h80, 1, 1, 0, 0};
    vecs[3]  = '{0, 8'h00, 0, 16'd0, 0, 8'h40, 1, 1, 0, 0};
    vecs[4]  = '{0, 8'h00, 0, 16'd0, 0, 8'h20, 1, 0, 1, 0};
    vecs[5]  = '{0, 8'h00, 0, 16'd0, 0, 8'h20, 0, 0, 0, 0};
    vecs[6]  = '{1, 8'h00, 0, 16'd0, 0, 8'h00, 0, 0, 0, 0};
    vecs[7]  = '{0, 8'h00, 0, 16'd0, 0, 8'h00, 0, 0, 0, 0};
    vecs[8]  = '{0, 8'h00, 1, 16'd2, 0, 8'h00, 0, 1, 0, 0};
    vecs[9]  = '{0, 8'h00, 0, 16'd0, 0, 8'h01, 1, 1, 0, 1};
    vecs[10] = '{0, 8'h00, 0, 16'd0, 0, 8'h80, 1, 0, 1, 1};
    vecs[11] = '{0, 8'h00, 0, 16'd0, 0, 8'h80, 0, 0, 0, 1};
    vecs[12] = '{1, 8'h01, 0, 16'd0, 0, 8'h01, 0, 0, 0, 0};
    vecs[13] = '{0, 8'h00, 1, 16'd5, 0, 8'h01, 0, 1, 0, 0};
    vecs[14] = '{0, 8'h00, 1, 16'd0, 0, 8'h80, 1, 1, 0, 0};
    vecs[15] = '{0, 8'h00, 0, 16'd0, 0, 8'h40, 1, 1, 0, 0};
    vecs[16] = '{1, 8'h10, 0, 16'd0, 0, 8'h10, 0, 1, 0, 0};
    // 0x10 -> 0x88 -> 0xC4 -> 0xE2 with taps on bits 0,2,3,4
    vecs[17] = '{0, 8'h00, 0, 16'd0, 0, 8'h88, 1, 1, 0, 0};
    vecs[18] = '{0, 8'h00, 0, 16'd0, 0, 8'hC4, 1, 1, 0, 0};
    vecs[19] = '{0, 8'h00, 0, 16'd0, 0, 8'hE2, 1, 0, 1, 0};
    vecs[20] = '{0, 8'h00, 0, 16'd0, 0, 8'hE2, 0, 0, 0, 0};
    vecs[21] = '{0, 8'h00, 0, 16'd0, 1, 8'hE2, 0, 0, 0, 0};
    vecs[22] = '{0, 8'h00, 1, 16'd0, 0, 8'hE2, 0, 1, 0, 0};
    vecs[23] = '{0, 8'h00, 0, 16'd0, 0, 8'h71, 1, 1, 0, 0};
    vecs[24] = '{0, 8'h00, 0, 16'd0, 0, 8'h38, 1, 1, 0, 0};
    vecs[25] = '{1, 8'h20, 0, 16'd0, 1, 8'h20, 0, 0, 0, 0};
    vecs[26] = '{0, 8'h00, 0, 16'd0, 0, 8'h20, 0, 0, 0, 0};

    rst_n = 1'b0; load = 1'b0; seed_in = '0; start = 1'b0; steps = '0; stop = 1'b0;
    #12;
    chk("reset_outputs", 32'(outs()), 32'({8'h01, 4'b0000}));
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      load = vecs[i].ld; seed_in = vecs[i].sd; start = vecs[i].st;
      steps = vecs[i].n; stop = vecs[i].sp;
      @(posedge clk); #1;
      chk($sformatf("vec%0d {data,vld,busy,done,lock}", i), 32'(outs()),
          32'({vecs[i].e_data, vecs[i].e_vld, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_lock}));
    end

    // Full-period free-run from 0x01
    @(negedge clk); load = 1'b1; seed_in = 8'h01; start = 1'b0; stop = 1'b0;
    @(negedge clk); load = 1'b0; start = 1'b1; steps = 16'd0;
    @(negedge clk); start = 1'b0;
    cnt = 0; found = 1'b0; rep = 1'b0; done_seen = 1'b0;
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
      if (data_valid) begin
        cnt++;
        if (data_out == 8'h01) begin
          found = 1'b1;
          break;
        end
        if (seen[data_out]) rep = 1'b1;
        seen[data_out] = 1'b1;
      end
    end
    chk("period_return_found", 32'(found), 32'd1);
    chk("period_length", 32'(cnt), 32'd255);
    chk("period_no_early_repeat", 32'(rep), 32'd0);
    chk("freerun_no_done", 32'(done_seen), 32'd0);
    @(negedge clk); stop = 1'b1;
    @(posedge clk); #1;
    chk("stop_freerun {data,vld,busy,done,lock}", 32'(outs()), 32'({8'h01, 4'b0000}));
    @(negedge clk); stop = 1'b0;

    // Reset in the middle of a counted burst, with lockup set
    @(negedge clk); load = 1'b1; seed_in = 8'h00;
    @(negedge clk); load = 1'b0; start = 1'b1; steps = 16'd10;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk("zero_recovery {data,vld,busy,done,lock}", 32'(outs()), 32'({8'h01, 4'b1101}));
    @(posedge clk); #1;
    chk("midburst_step data", 32'(data_out), 32'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset {data,vld,busy,done,lock}", 32'(outs()), 32'({8'h01, 4'b0000}));
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done || busy || data_valid || data_out != 8'h01) bad = 1'b1;
    end
    chk("post_reset_idle_no_done", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
